// File: rtl/db_pkg.sv
// Shared types and constants for the switch debouncer.
package db_pkg;

  localparam int DB_N_DEFAULT = 19;

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    WAIT1_1 = 3'd1,
    WAIT1_2 = 3'd2,
    WAIT1_3 = 3'd3,
    ONE     = 3'd4,
    WAIT0_1 = 3'd5,
    WAIT0_2 = 3'd6,
    WAIT0_3 = 3'd7
  } db_state_t;

endpackage

// File: rtl/db_tick_gen.sv
// Free-running N-bit counter producing a one-cycle tick every 2^N clocks (at q == 0).
// Counter is cleared only by reset, so the first tick lands in the first cycle after release.
module db_tick_gen
  import db_pkg::*;
#(
  parameter int N = DB_N_DEFAULT
) (
  input  logic clk_amisha,
  input  logic reset_amisha,
  output logic m_tick
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      r_q <= '0;
    end else begin
      r_q <= r_q + N'(1);
    end
  end

  assign m_tick = (r_q == '0);

endmodule

// File: rtl/db_fsm.sv
// Moore debouncer: db follows sw only after sw stays put across three counter ticks.
// Latency 2*2^N+2 .. 3*2^N+1 edges; any reversal while waiting returns to the stable state.
module db_fsm
  import db_pkg::*;
#(
  parameter int N = DB_N_DEFAULT
) (
  input  logic clk_amisha,
  input  logic reset_amisha,
  input  logic sw_amisha,
  output logic db_amisha
);

  logic      w_tick;
  db_state_t r_state;
  db_state_t w_next;

  db_tick_gen #(.N(N)) u_tick (
    .clk_amisha  (clk_amisha),
    .reset_amisha(reset_amisha),
    .m_tick      (w_tick)
  );

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      r_state <= ZERO;
    end else begin
      r_state <= w_next;
    end
  end

  // A reversal of sw in any wait state wins over a coincident tick.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ZERO:    if (sw_amisha) w_next = WAIT1_1;
      WAIT1_1: if (!sw_amisha) w_next = ZERO; else if (w_tick) w_next = WAIT1_2;
      WAIT1_2: if (!sw_amisha) w_next = ZERO; else if (w_tick) w_next = WAIT1_3;
      WAIT1_3: if (!sw_amisha) w_next = ZERO; else if (w_tick) w_next = ONE;
      ONE:     if (!sw_amisha) w_next = WAIT0_1;
      WAIT0_1: if (sw_amisha) w_next = ONE; else if (w_tick) w_next = WAIT0_2;
      WAIT0_2: if (sw_amisha) w_next = ONE; else if (w_tick) w_next = WAIT0_3;
      WAIT0_3: if (sw_amisha) w_next = ONE; else if (w_tick) w_next = ZERO;
      default: w_next = ZERO;
    endcase
  end

  assign db_amisha = (r_state == ONE) || (r_state == WAIT0_1) ||
                     (r_state == WAIT0_2) || (r_state == WAIT0_3);

endmodule

// File: tb/tb_db_fsm.sv
// Bench for db_fsm with N=3: tick-counting reference model, per-cycle compare, directed and random stimulus.
module tb_db_fsm;
  import db_pkg::*;

  localparam int N = 3;
  localparam int P = 1 << N;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sw = 1'b0;
  logic db;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference: stable level, whether a change is pending, ticks seen while pending, counter phase.
  bit db_m = 1'b0;
  bit pend = 1'b0;
  int ticks = 0;
  int q_m = 0;

  db_fsm #(.N(N)) dut (
    .clk_amisha  (clk),
    .reset_amisha(rst_n),
    .sw_amisha   (sw),
    .db_amisha   (db)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit s, input bit tick);
    if (!pend) begin
      if (s != db_m) begin
        pend = 1'b1;
        ticks = 0;
      end
    end else if (s == db_m) begin
      pend = 1'b0;
    end else if (tick) begin
      ticks++;
      if (ticks == 3) begin
        db_m = ~db_m;
        pend = 1'b0;
      end
    end
  endtask

  // Called at a negedge; returns at the following negedge with the model advanced.
  task automatic cyc(input bit s);
    sw = s;
    @(posedge clk);
    model_step(s, q_m == 0);
    q_m = (q_m + 1) % P;
    @(negedge clk);
  endtask

  task automatic measure(input bit s, input int n, output int lat);
    lat = -1;
    for (int i = 1; i <= n; i++) begin
      cyc(s);
      if (lat < 0 && db === s) lat = i;
    end
  endtask

  task automatic do_reset(input bit s);
    sw = s;
    #20 rst_n = 1'b0;
    db_m = 1'b0;
    pend = 1'b0;
    q_m = 0;
    #1 check("reset_db_async", db, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", dut.r_state, ZERO);
    check("reset_q", dut.u_tick.r_q, 0);
    check("reset_db_held", db, 0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("db", db, db_m);
      check("tick", dut.u_tick.m_tick, (q_m == 0));
    end
  end

  initial begin
    int lat;
    int nt;
    bit seen;
    sw = 1'b1;
    #10 rst_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    do_reset(1'b1);

    // Clean press from a known phase: change sampled at q=3, ticks at q=0 give 22 edges.
    repeat (3) cyc(1'b0);
    measure(1'b1, 40, lat);
    check("press_latency", lat, 22);
    check("model_press", db_m, 1);
    repeat (10) cyc(1'b1);

    // Return to 0, then bounce and short pulses must not raise db.
    measure(1'b0, 40, lat);
    check("release_in_window", (lat >= 18 && lat <= 25), 1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(i[0]);
      if (db !== 1'b0) seen = 1'b1;
    end
    repeat (5) begin cyc(1'b1); if (db !== 1'b0) seen = 1'b1; end
    repeat (12) begin cyc(1'b0); if (db !== 1'b0) seen = 1'b1; end
    check("bounce_db_low", seen, 0);

    // Press, 0-glitch while high, then clean release.
    measure(1'b1, 40, lat);
    check("press2_in_window", (lat >= 18 && lat <= 25), 1);
    seen = 1'b0;
    repeat (5) begin cyc(1'b0); if (db !== 1'b1) seen = 1'b1; end
    repeat (12) begin cyc(1'b1); if (db !== 1'b1) seen = 1'b1; end
    check("glitch_db_high", seen, 0);
    measure(1'b0, 40, lat);
    check("release2_in_window", (lat >= 18 && lat <= 25), 1);
    check("model_release", db_m, 0);

    // Reset while waiting for a press; after release the full delay restarts (tick at first edge is ignored).
    repeat (12) cyc(1'b1);
    do_reset(1'b1);
    measure(1'b1, 40, lat);
    check("post_reset_latency", lat, 25);

    // Counter wrap: exactly one tick per 8 cycles.
    nt = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1);
      if (dut.u_tick.m_tick === 1'b1) nt++;
    end
    check("tick_count_64", nt, 8);

    // Random runs of stable levels of varying length.
    for (int r = 0; r < 120; r++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 30));
      repeat (len) cyc(lvl);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
